// File: rtl/rbusd_fill_collector_if.sv
// rbusd_fill_collector_if
//   Request bus (reqBus_*) and reply data bus (insBus_*) between a line-fill
//   requester and the L2 side.
//   master : requester/receiver end (drives reqBus_want/addr/req/want_excl,
//            samples reqBus_can and all insBus_* signals).
//   slave  : L2 end (the mirror image).
interface rbusd_fill_collector_if #(
   parameter int unsigned ADDR_WIDTH = 37,
   parameter int unsigned DATA_WIDTH = 512
);
   logic                  reqBus_want;
   logic                  reqBus_can;
   logic [ADDR_WIDTH-1:0] reqBus_addr;
   logic [4:0]            reqBus_req;
   logic                  reqBus_want_excl;

   logic                  insBus_used;
   logic                  insBus_second;
   logic [4:0]            insBus_req;
   logic                  insBus_dirty;
   logic                  insBus_excl;
   logic [DATA_WIDTH-1:0] insBus_data;

   modport master (
      output reqBus_want, reqBus_addr, reqBus_req, reqBus_want_excl,
      input  reqBus_can,
      input  insBus_used, insBus_second, insBus_req, insBus_dirty, insBus_excl, insBus_data
   );

   modport slave (
      input  reqBus_want, reqBus_addr, reqBus_req, reqBus_want_excl,
      output reqBus_can,
      output insBus_used, insBus_second, insBus_req, insBus_dirty, insBus_excl, insBus_data
   );
endinterface

// File: rtl/rbusd_fill_collector.sv
// rbusd_fill_collector
//   Accepts line misses into REQ_SLOTS request slots, issues them on reqBus
//   with a want/can handshake (slot index = request ID), and reassembles the
//   two-beat insBus replies into full-line fills.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   miss_en/addr/excl  miss request in; miss_ready = a slot is free
//   bus (master)       reqBus_* request out, insBus_* reply beats in
//   fill_*             one-cycle assembled line fill {second, first}
//   outstanding        number of busy slots
//   err_en             one-cycle pulse on a reply protocol violation
module rbusd_fill_collector #(
   parameter int unsigned REQ_SLOTS  = 4,
   parameter int unsigned ADDR_WIDTH = 37,
   parameter int unsigned DATA_WIDTH = 512
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    miss_en,
   input  logic [ADDR_WIDTH-1:0]   miss_addr,
   input  logic                    miss_excl,
   output logic                    miss_ready,
   rbusd_fill_collector_if.master  bus,
   output logic                    fill_en,
   output logic [ADDR_WIDTH-1:0]   fill_addr,
   output logic [2*DATA_WIDTH-1:0] fill_data,
   output logic                    fill_dirty,
   output logic                    fill_excl,
   output logic [3:0]              outstanding,
   output logic                    err_en
);
   localparam int unsigned IDW = (REQ_SLOTS > 1) ? $clog2(REQ_SLOTS) : 1;

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_PEND   = 2'd1;
   localparam logic [1:0] ST_ISSUED = 2'd2;
   localparam logic [1:0] ST_HALF   = 2'd3;

   logic [1:0]            r_state [REQ_SLOTS];
   logic [ADDR_WIDTH-1:0] r_addr  [REQ_SLOTS];
   logic                  r_excl  [REQ_SLOTS];

   logic                  r_want;
   logic [IDW-1:0]        r_req_id;

   logic                  r_half_vld;
   logic [IDW-1:0]        r_half_id;
   logic [DATA_WIDTH-1:0] r_half_data;
   logic                  r_half_dirty;
   logic                  r_half_excl;

   logic                    r_fill_en;
   logic [ADDR_WIDTH-1:0]   r_fill_addr;
   logic [2*DATA_WIDTH-1:0] r_fill_data;
   logic                    r_fill_dirty;
   logic                    r_fill_excl;
   logic                    r_err_en;

   logic           w_any_free;
   logic [IDW-1:0] w_alloc_id;
   logic           w_accept;
   logic           w_hs;
   logic           w_next_vld;
   logic [IDW-1:0] w_next_id;
   logic [3:0]     w_outstanding;
   logic           w_id_ok;
   logic [IDW-1:0] w_id;
   logic           w_first;
   logic           w_fill;
   logic           w_err;

   // Lowest-index free slot and busy count, from registered state only.
   always_comb begin
      w_any_free    = 1'b0;
      w_alloc_id    = '0;
      w_outstanding = '0;
      for (int unsigned i = 0; i < REQ_SLOTS; i++) begin
         if (r_state[i] == ST_FREE) begin
            if (!w_any_free) w_alloc_id = i[IDW-1:0];
            w_any_free = 1'b1;
         end else begin
            w_outstanding = w_outstanding + 4'd1;
         end
      end
   end

   assign miss_ready = rst & w_any_free;
   assign w_accept   = miss_en & miss_ready;
   assign w_hs       = r_want & bus.reqBus_can;

   // The presented request is latched so addr/req/excl stay stable while
   // stalled, even if a lower free slot is allocated meanwhile. A slot being
   // allocated this edge is already a candidate, giving want one cycle later.
   always_comb begin
      w_next_vld = 1'b0;
      w_next_id  = '0;
      for (int unsigned i = 0; i < REQ_SLOTS; i++) begin
         if (!w_next_vld &&
             ((r_state[i] == ST_PEND && !(w_hs && 32'(r_req_id) == i)) ||
              (w_accept && 32'(w_alloc_id) == i))) begin
            w_next_vld = 1'b1;
            w_next_id  = i[IDW-1:0];
         end
      end
   end

   // Reply decode. While a half line is buffered, anything but its second
   // beat aborts it; the offending beat itself is not otherwise acted on.
   assign w_id_ok = 32'(bus.insBus_req) < REQ_SLOTS;
   assign w_id    = bus.insBus_req[IDW-1:0];
   assign w_fill  = r_half_vld & bus.insBus_used & bus.insBus_second &
                    (32'(bus.insBus_req) == 32'(r_half_id));
   assign w_first = !r_half_vld && bus.insBus_used && !bus.insBus_second &&
                    w_id_ok && (r_state[w_id] == ST_ISSUED);
   assign w_err   = (r_half_vld && !w_fill) ||
                    (!r_half_vld && bus.insBus_used && !w_first);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < REQ_SLOTS; i++) begin
            r_state[i] <= ST_FREE;
            r_addr[i]  <= '0;
            r_excl[i]  <= 1'b0;
         end
         r_want       <= 1'b0;
         r_req_id     <= '0;
         r_half_vld   <= 1'b0;
         r_half_id    <= '0;
         r_half_data  <= '0;
         r_half_dirty <= 1'b0;
         r_half_excl  <= 1'b0;
         r_fill_en    <= 1'b0;
         r_fill_addr  <= '0;
         r_fill_data  <= '0;
         r_fill_dirty <= 1'b0;
         r_fill_excl  <= 1'b0;
         r_err_en     <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < REQ_SLOTS; i++) begin
            if (w_accept && 32'(w_alloc_id) == i) begin
               r_state[i] <= ST_PEND;
               r_addr[i]  <= miss_addr;
               r_excl[i]  <= miss_excl;
            end else if (w_hs && 32'(r_req_id) == i) begin
               r_state[i] <= ST_ISSUED;
            end else if (w_first && 32'(w_id) == i) begin
               r_state[i] <= ST_HALF;
            end else if (r_half_vld && 32'(r_half_id) == i) begin
               r_state[i] <= w_fill ? ST_FREE : ST_ISSUED;
            end
         end

         if (!(r_want && !bus.reqBus_can)) begin
            r_want   <= w_next_vld;
            r_req_id <= w_next_id;
         end

         r_half_vld <= w_first;
         if (w_first) begin
            r_half_id    <= w_id;
            r_half_data  <= bus.insBus_data;
            r_half_dirty <= bus.insBus_dirty;
            r_half_excl  <= bus.insBus_excl;
         end

         r_fill_en <= w_fill;
         if (w_fill) begin
            r_fill_addr  <= r_addr[r_half_id];
            r_fill_data  <= {bus.insBus_data, r_half_data};
            r_fill_dirty <= r_half_dirty;
            r_fill_excl  <= r_half_excl;
         end
         r_err_en <= w_err;
      end
   end

   assign bus.reqBus_want      = r_want;
   assign bus.reqBus_addr      = r_addr[r_req_id];
   assign bus.reqBus_req       = 5'(r_req_id);
   assign bus.reqBus_want_excl = r_excl[r_req_id];

   assign fill_en     = r_fill_en;
   assign fill_addr   = r_fill_addr;
   assign fill_data   = r_fill_data;
   assign fill_dirty  = r_fill_dirty;
   assign fill_excl   = r_fill_excl;
   assign outstanding = w_outstanding;
   assign err_en      = r_err_en;
endmodule

// File: tb/tb_rbusd_fill_collector.sv
// tb_rbusd_fill_collector
//   Directed scenarios plus randomized traffic against a transaction-level
//   model of the fill collector; every output is compared on each falling edge.
module tb_rbusd_fill_collector;
   localparam int NS = 4;
   localparam int AW = 37;
   localparam int DW = 512;

   logic            clk;
   logic            rst;
   logic            miss_en;
   logic [AW-1:0]   miss_addr;
   logic            miss_excl;
   logic            miss_ready;
   logic            fill_en;
   logic [AW-1:0]   fill_addr;
   logic [2*DW-1:0] fill_data;
   logic            fill_dirty;
   logic            fill_excl;
   logic [3:0]      outstanding;
   logic            err_en;

   rbusd_fill_collector_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   rbusd_fill_collector #(.REQ_SLOTS(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .miss_en     (miss_en),
      .miss_addr   (miss_addr),
      .miss_excl   (miss_excl),
      .miss_ready  (miss_ready),
      .bus         (bus),
      .fill_en     (fill_en),
      .fill_addr   (fill_addr),
      .fill_data   (fill_data),
      .fill_dirty  (fill_dirty),
      .fill_excl   (fill_excl),
      .outstanding (outstanding),
      .err_en      (err_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_wide(input string name, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got[63:0] %h got[1023:960] %h expected[63:0] %h expected[1023:960] %h (t=%0t)",
                  name, got[63:0], got[1023:960], exp[63:0], exp[1023:960], $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A slot is either idle, waiting to be sent, or sent and awaiting data.
   bit              m_busy [NS];
   bit              m_sent [NS];
   logic [AW-1:0]   m_addr [NS];
   bit              m_exc  [NS];
   int              m_pres = -1;   // request currently offered on reqBus
   int              m_half = -1;   // request whose first beat is buffered
   logic [DW-1:0]   m_hdata;
   bit              m_hdirty, m_hexcl;
   bit              e_fill_en = 0, e_err = 0, e_fill_dirty = 0, e_fill_excl = 0;
   logic [AW-1:0]   e_fill_addr = '0;
   logic [2*DW-1:0] e_fill_data = '0;

   always @(posedge clk or negedge rst) begin : model
      int alloc, rid, np;
      bit acc, hs, fill, first, err;
      if (!rst) begin
         for (int i = 0; i < NS; i++) begin
            m_busy[i] = 0;
            m_sent[i] = 0;
         end
         m_pres = -1;
         m_half = -1;
         e_fill_en = 0; e_err = 0; e_fill_dirty = 0; e_fill_excl = 0;
         e_fill_addr = '0; e_fill_data = '0;
      end else begin
         alloc = -1;
         for (int i = NS - 1; i >= 0; i--) if (!m_busy[i]) alloc = i;
         acc   = miss_en && (alloc >= 0);
         hs    = (m_pres >= 0) && bus.reqBus_can;
         rid   = int'(bus.insBus_req);
         fill  = 0; first = 0; err = 0;
         if (m_half >= 0) begin
            if (bus.insBus_used && bus.insBus_second && rid == m_half) fill = 1;
            else err = 1;
         end else if (bus.insBus_used) begin
            if (!bus.insBus_second && rid < NS && m_busy[rid] && m_sent[rid]) first = 1;
            else err = 1;
         end
         e_fill_en = fill;
         e_err     = err;
         if (fill) begin
            e_fill_data  = {bus.insBus_data, m_hdata};
            e_fill_addr  = m_addr[m_half];
            e_fill_dirty = m_hdirty;
            e_fill_excl  = m_hexcl;
         end
         if (m_pres >= 0 && !bus.reqBus_can) np = m_pres;
         else begin
            np = -1;
            for (int j = NS - 1; j >= 0; j--)
               if ((m_busy[j] && !m_sent[j] && !(hs && j == m_pres)) || (acc && j == alloc)) np = j;
         end
         if (hs) m_sent[m_pres] = 1;
         if (first) begin
            m_half   = rid;
            m_hdata  = bus.insBus_data;
            m_hdirty = bus.insBus_dirty;
            m_hexcl  = bus.insBus_excl;
         end else if (m_half >= 0) begin
            if (fill) begin
               m_busy[m_half] = 0;
               m_sent[m_half] = 0;
            end
            m_half = -1;
         end
         if (acc) begin
            m_busy[alloc] = 1;
            m_sent[alloc] = 0;
            m_addr[alloc] = miss_addr;
            m_exc[alloc]  = miss_excl;
         end
         m_pres = np;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin : compare
      int cnt;
      bit anyfree;
      cnt = 0;
      anyfree = 0;
      for (int i = 0; i < NS; i++) begin
         if (m_busy[i]) cnt++;
         else anyfree = 1;
      end
      chk("miss_ready", miss_ready, rst && anyfree);
      chk("outstanding", outstanding, cnt);
      chk("reqBus_want", bus.reqBus_want, m_pres >= 0);
      if (m_pres >= 0) begin
         chk("reqBus_req", bus.reqBus_req, m_pres);
         chk("reqBus_addr", bus.reqBus_addr, m_addr[m_pres]);
         chk("reqBus_want_excl", bus.reqBus_want_excl, m_exc[m_pres]);
      end
      chk("err_en", err_en, e_err);
      chk("fill_en", fill_en, e_fill_en);
      chk("fill_addr", fill_addr, e_fill_addr);
      chk("fill_dirty", fill_dirty, e_fill_dirty);
      chk("fill_excl", fill_excl, e_fill_excl);
      chk_wide("fill_data", fill_data, e_fill_data);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic beat(input int id, input bit sec, input logic [DW-1:0] d, input bit dirty, input bit excl);
      bus.insBus_used   = 1'b1;
      bus.insBus_second = sec;
      bus.insBus_req    = 5'(id);
      bus.insBus_data   = d;
      bus.insBus_dirty  = dirty;
      bus.insBus_excl   = excl;
   endtask

   task automatic idle_beat();
      bus.insBus_used   = 1'b0;
      bus.insBus_second = 1'b0;
   endtask

   task automatic reply(input int id, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit dirty, input bit excl);
      beat(id, 1'b0, d0, dirty, excl);
      step();
      beat(id, 1'b1, d1, 1'b0, 1'b0);
      step();
      idle_beat();
   endtask

   task automatic miss(input logic [AW-1:0] a, input bit x);
      miss_en   = 1'b1;
      miss_addr = a;
      miss_excl = x;
      step();
      miss_en   = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   initial begin : stim
      logic [DW-1:0] pa, pb;
      logic [63:0]   a64;
      int            q[$];
      int            r;
      pa = {64{8'hAA}};
      pb = {64{8'hBB}};
      rst = 1'b1;
      miss_en = 1'b0; miss_addr = '0; miss_excl = 1'b0;
      bus.reqBus_can = 1'b0;
      bus.insBus_used = 1'b0; bus.insBus_second = 1'b0; bus.insBus_req = '0;
      bus.insBus_dirty = 1'b0; bus.insBus_excl = 1'b0; bus.insBus_data = '0;
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_want", bus.reqBus_want, 0);
      chk("rst_fill_en", fill_en, 0);
      chk("rst_err_en", err_en, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_miss_ready", miss_ready, 0);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_miss_ready", miss_ready, 1);

      // single miss
      bus.reqBus_can = 1'b1;
      miss(37'h1000, 1'b0);
      @(negedge clk);
      chk("single_want", bus.reqBus_want, 1);
      chk("single_req", bus.reqBus_req, 0);
      chk("single_addr", bus.reqBus_addr, 37'h1000);
      step();
      reply(0, pa, pb, 1'b0, 1'b0);
      @(negedge clk);
      chk("single_fill_en", fill_en, 1);
      chk("single_fill_addr", fill_addr, 37'h1000);
      chk_wide("single_fill_data", fill_data, {pb, pa});
      step();

      // back-pressure then out-of-order replies
      bus.reqBus_can = 1'b0;
      miss(37'h2000, 1'b0);
      miss(37'h2040, 1'b1);
      miss(37'h2080, 1'b0);
      repeat (5) step();
      @(negedge clk);
      chk("bp_want_held", bus.reqBus_want, 1);
      chk("bp_req_held", bus.reqBus_req, 0);
      chk("bp_addr_held", bus.reqBus_addr, 37'h2000);
      bus.reqBus_can = 1'b1;
      step();
      @(negedge clk);
      chk("bp_next_req", bus.reqBus_req, 1);
      step();
      step();
      @(negedge clk);
      chk("bp_outstanding", outstanding, 3);
      chk("bp_drained_want", bus.reqBus_want, 0);
      reply(1, rnd_data(), rnd_data(), 1'b1, 1'b1);
      @(negedge clk);
      chk("ooo_fill1_addr", fill_addr, 37'h2040);
      chk("ooo_fill1_dirty", fill_dirty, 1);
      reply(0, rnd_data(), rnd_data(), 1'b0, 1'b0);
      @(negedge clk);
      chk("ooo_fill0_addr", fill_addr, 37'h2000);
      chk("ooo_fill0_dirty", fill_dirty, 0);
      reply(2, rnd_data(), rnd_data(), 1'b0, 1'b1);
      step();

      // full
      for (int i = 0; i < NS; i++) miss(37'h3000 + 37'(i * 64), 1'b0);
      repeat (4) step();
      @(negedge clk);
      chk("full_ready", miss_ready, 0);
      chk("full_outstanding", outstanding, 4);
      miss(37'h1_9999, 1'b1);
      reply(2, rnd_data(), rnd_data(), 1'b0, 1'b0);
      @(negedge clk);
      chk("full_ready_after_free", miss_ready, 1);
      miss(37'h4000, 1'b0);
      @(negedge clk);
      chk("full_reuse_req", bus.reqBus_req, 2);
      chk("full_reuse_addr", bus.reqBus_addr, 37'h4000);
      step();
      reply(0, rnd_data(), rnd_data(), 1'b0, 1'b0);
      reply(1, rnd_data(), rnd_data(), 1'b1, 1'b0);
      reply(3, rnd_data(), rnd_data(), 1'b0, 1'b1);
      reply(2, rnd_data(), rnd_data(), 1'b1, 1'b1);
      step();

      // protocol errors
      beat(3, 1'b0, rnd_data(), 1'b0, 1'b0);
      step();
      idle_beat();
      @(negedge clk);
      chk("err_idle_beat", err_en, 1);
      chk("err_idle_outstanding", outstanding, 0);
      miss(37'h5000, 1'b0);
      step();
      beat(0, 1'b0, rnd_data(), 1'b1, 1'b0);
      step();
      idle_beat();
      step();
      @(negedge clk);
      chk("err_gap", err_en, 1);
      reply(0, pa, pb, 1'b0, 1'b0);
      @(negedge clk);
      chk("err_recover_fill", fill_en, 1);
      chk("err_recover_addr", fill_addr, 37'h5000);
      step();

      // reset mid-reply
      miss(37'h6000, 1'b0);
      step();
      beat(0, 1'b0, rnd_data(), 1'b0, 1'b0);
      step();
      idle_beat();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_outstanding", outstanding, 0);
      chk("mid_rst_fill_en", fill_en, 0);
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("mid_rst_no_err", err_en, 0);
      miss(37'h7000, 1'b0);
      @(negedge clk);
      chk("mid_rst_fresh_req", bus.reqBus_req, 0);
      chk("mid_rst_fresh_want", bus.reqBus_want, 1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         miss_en = ($urandom_range(9, 0) < 4);
         a64 = {$urandom(), $urandom()};
         miss_addr = a64[AW-1:0];
         miss_excl = 1'($urandom_range(1, 0));
         bus.reqBus_can = ($urandom_range(9, 0) < 6);
         r = int'($urandom_range(99, 0));
         if (m_half >= 0) begin
            if (r < 90) beat(m_half, 1'b1, rnd_data(), 1'b0, 1'b0);
            else if (r < 95) idle_beat();
            else beat(int'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), rnd_data(), 1'b0, 1'b0);
         end else begin
            q.delete();
            for (int i = 0; i < NS; i++) if (m_busy[i] && m_sent[i]) q.push_back(i);
            if (q.size() > 0 && r < 40)
               beat(q[$urandom_range(q.size() - 1, 0)], 1'b0, rnd_data(),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            else if (r >= 95)
               beat(int'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), rnd_data(), 1'b0, 1'b0);
            else
               idle_beat();
         end
         step();
      end
      miss_en = 1'b0;
      idle_beat();
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rbusd_fill_collector.md
# rbusd_fill_collector

Line-fill requester and reply collector for the rbus/rbusD pair, sitting between a cache miss source and the L2 side. It accepts line-miss requests, issues them on the request bus with a want/can handshake, tags each request with a slot ID, and reassembles the two-beat 512-bit rbusD replies into 1024-bit line fills. It implements the requester and receiver end of the interface `dummyL2` serves.

## Interface
Parameters:
- REQ_SLOTS, 4, maximum outstanding requests (1..8); the slot index is the request ID.
- ADDR_WIDTH, 37, line address width.
- DATA_WIDTH, 512, beat width; a line is 2*DATA_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset. Low clears all state immediately.
- miss_en  in  1  line-miss request valid.
- miss_addr  in  ADDR_WIDTH  line address.
- miss_excl  in  1  exclusive ownership wanted.
- miss_ready  out  1  a free slot exists; miss accepted when miss_en&miss_ready at posedge.
- reqBus_want  out  1  request valid (registered).
- reqBus_can  in  1  bus accepts this cycle.
- reqBus_addr  out  ADDR_WIDTH  request address.
- reqBus_req  out  5  request ID = slot index, zero-extended.
- reqBus_want_excl  out  1  exclusive request.
- insBus_used  in  1  reply beat valid.
- insBus_second  in  1  beat is the second (upper) half.
- insBus_req  in  5  destination request ID.
- insBus_dirty  in  1  line dirty (sampled on first beat).
- insBus_excl  in  1  line granted exclusive (sampled on first beat).
- insBus_data  in  DATA_WIDTH  beat data.
- fill_en  out  1  one-cycle pulse, assembled line valid.
- fill_addr  out  ADDR_WIDTH  address of filled line.
- fill_data  out  2*DATA_WIDTH  {second beat, first beat}.
- fill_dirty, fill_excl  out  1 each  attributes from first beat.
- outstanding  out  4  count of non-FREE slots.
- err_en  out  1  one-cycle pulse on protocol violation.

## Operation
- Per slot: state FREE/PEND/ISSUED/HALF, address, excl bit. A single shared low-half buffer holds first-beat data, dirty, excl and ID.
- Allocation: accepted miss goes to the lowest-index FREE slot and becomes PEND.
- Issue: the lowest-index PEND slot drives reqBus_*. reqBus_want is held with stable addr/req/excl until reqBus_can=1 at a posedge; that slot then moves to ISSUED.
- First beat: used=1, second=0, ID in ISSUED state. Capture data, dirty and excl into the buffer; the slot moves to HALF.
- Second beat: used=1, second=1, ID equal to the HALF slot. Assert fill_en with the assembled line; the slot becomes FREE.
- Beats must be contiguous. If a slot is HALF and the next cycle is not its second beat, pulse err_en, discard the half, and return the slot to ISSUED.
- Errors: a beat addressed to a FREE or PEND slot, an ID ≥ REQ_SLOTS, or a second beat with no matching HALF slot pulses err_en and is otherwise ignored.
- miss_ready is derived from registered state only. A slot freed this cycle is reusable next cycle.
- Reset (rst low): all slots FREE. reqBus_want, fill_en, err_en, fill_* are 0; outstanding=0; miss_ready=0 while rst is low and 1 once it is released.

## Timing
- Miss accepted at edge N: reqBus_want=1 from N+1 at the earliest.
- Handshake at edge M: the next PEND slot is presented from M+1. At most one request issues per cycle.
- Second beat at edge K: fill_en, fill_data, fill_addr, fill_dirty and fill_excl are valid in cycle K+1 for exactly one cycle. The slot is FREE after K, so miss_ready can rise in K+1.
- outstanding updates one cycle after allocation or free. A simultaneous allocate and free leaves it unchanged.
- An rst assertion mid-reply drops the partial line with no fill_en and no err_en.

## Test plan
- Single miss: addr=0x1000, reqBus_can=1. Expect want at N+1 with req=0. Reply beats 0xAA..(first) and 0xBB..(second) produce fill_en one cycle later with fill_data={0xBB..,0xAA..} and fill_addr=0x1000.
- Back-pressure: 3 misses with reqBus_can=0 for 5 cycles. want stays high with req=0 stable; then IDs 0, 1, 2 issue on consecutive cycles; outstanding=3.
- Full: 4 misses outstanding. miss_ready=0 and a 5th miss_en is ignored. Completing ID 2 makes miss_ready=1 the next cycle, and the next miss reuses slot 2.
- Out-of-order replies: ID 1 then ID 0. Two fill_en pulses arrive with the correct addresses in reply order; dirty=1 on ID 1 is reflected only on its fill.
- Protocol errors: a first beat for ID 3 while idle gives err_en=1 and no state change. A first beat for ID 0 followed by an idle cycle gives err_en=1, ID 0 returns to ISSUED, and a later complete reply still fills correctly.
- Reset mid-reply: drive rst low between beats. Afterwards outstanding=0, no fill_en occurs, and a fresh miss issues as ID 0.
